// File: rtl/miriscv_pkg.sv
// Shared widths and bus payload types for the miriscv core.
package miriscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Prefetch FIFO of fetched {instr, pc} entries with synchronous flush.
// Push and pop may coincide at any occupancy, including full.
module miriscv_fetch_fifo
    import miriscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         srstn_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        if (push_i) wr_d = wr_q + PW'(1);
        if (pop_i)  rd_d = rd_q + PW'(1);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is data only; validity is tracked by the count.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/miriscv_fetch_stage_pf.sv
// Prefetching fetch stage: pipelined req/gnt instruction fetch, prefetch FIFO,
// discard counting of stale responses after a redirect, stall/kill output register.
module miriscv_fetch_stage_pf
    import miriscv_pkg::*;
#(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic              clk_i,
    input  logic              srstn_i,
    input  logic              cu_kill_f_i,
    input  logic              cu_stall_f_i,
    input  logic              cu_force_f_i,
    input  logic [XLEN-1:0]   cu_force_pc_i,
    output logic              f_stall_req_o,
    output logic              instr_req_o,
    output logic [XLEN-1:0]   instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [XLEN-1:0]   instr_rdata_i,
    output logic [ILEN-1:0]   f_instr_o,
    output logic [XLEN-1:0]   f_current_pc_o,
    output logic [XLEN-1:0]   f_next_pc_o,
    output logic              f_valid_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            run_q;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    fetch_entry_t    out_q, out_d;
    logic            valid_q, valid_d;

    fetch_entry_t    fifo_head;
    fetch_entry_t    resp_entry;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     pending;
    logic            grant, keep, drop, load, pop, bypass, push;

    // Requests whose responses will still occupy a FIFO slot, plus current occupancy.
    assign pending = (CW+1)'(inflight_q - discard_q) + (CW+1)'(fifo_cnt);

    assign instr_req_o  = run_q & srstn_i & ~cu_force_f_i
                        & (inflight_q < CW'(MAX_OUTST))
                        & (pending < (CW+1)'(DEPTH));
    assign instr_addr_o = req_pc_q;
    assign grant        = instr_req_o & instr_gnt_i;

    assign keep       = instr_rvalid_i & (discard_q == '0);
    assign drop       = instr_rvalid_i & (discard_q != '0);
    assign resp_entry = '{instr: ILEN'(instr_rdata_i), pc: resp_pc_q};

    assign load   = ~cu_kill_f_i & ~cu_force_f_i & ~cu_stall_f_i;
    assign pop    = load & ~fifo_empty;
    assign bypass = load & fifo_empty & keep;
    assign push   = keep & ~cu_force_f_i & ~bypass;

    always_comb begin
        req_pc_d   = req_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(grant) - CW'(instr_rvalid_i);
        discard_d  = discard_q;
        out_d      = out_q;
        valid_d    = valid_q;

        if (grant) req_pc_d  = req_pc_q + XLEN'(4);
        if (keep)  resp_pc_d = resp_pc_q + XLEN'(4);
        if (drop)  discard_d = discard_q - CW'(1);

        // Everything still outstanding after this cycle becomes stale.
        if (cu_force_f_i) begin
            req_pc_d  = cu_force_pc_i;
            resp_pc_d = cu_force_pc_i;
            discard_d = inflight_q - CW'(instr_rvalid_i);
        end

        if (cu_kill_f_i || cu_force_f_i) begin
            valid_d = 1'b0;
        end else if (!cu_stall_f_i) begin
            if (!fifo_empty) begin
                out_d   = fifo_head;
                valid_d = 1'b1;
            end else if (keep) begin
                out_d   = resp_entry;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            run_q      <= 1'b0;
            req_pc_q   <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            req_pc_q   <= req_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        out_q <= out_d;
    end

    miriscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .srstn_i (srstn_i),
        .flush_i (cu_force_f_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (resp_entry),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

    assign f_stall_req_o  = 1'b0;
    assign f_instr_o      = out_q.instr;
    assign f_current_pc_o = out_q.pc;
    assign f_next_pc_o    = out_q.pc + XLEN'(4);
    assign f_valid_o      = valid_q;

    rvalid_without_request : assert property (
        @(posedge clk_i) disable iff (!srstn_i) !(instr_rvalid_i && (inflight_q == '0))
    );

endmodule

// File: tb/tb_miriscv_fetch_stage_pf.sv
// Scoreboard bench for the prefetching fetch stage with a simple in-order memory model.
module tb_miriscv_fetch_stage_pf;
    import miriscv_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0080;
    localparam logic [31:0] KEY       = 32'h1357_9BDF;

    logic        clk_i = 1'b0;
    logic        srstn_i = 1'b0;
    logic        cu_kill_f_i = 1'b0, cu_stall_f_i = 1'b0, cu_force_f_i = 1'b0;
    logic [31:0] cu_force_pc_i = '0;
    logic        f_stall_req_o, instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic [31:0] f_instr_o, f_current_pc_o, f_next_pc_o;
    logic        f_valid_o;

    miriscv_fetch_stage_pf #(
        .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk_i), .srstn_i(srstn_i),
        .cu_kill_f_i(cu_kill_f_i), .cu_stall_f_i(cu_stall_f_i),
        .cu_force_f_i(cu_force_f_i), .cu_force_pc_i(cu_force_pc_i),
        .f_stall_req_o(f_stall_req_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .f_instr_o(f_instr_o), .f_current_pc_o(f_current_pc_o),
        .f_next_pc_o(f_next_pc_o), .f_valid_o(f_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0;
    int          grants_left = 0, lat_min = 1, lat_max = 1, gnt_off = 0;
    bit          gnt_rand = 1'b0;
    bit          rst_v = 1'b0, kill_v = 1'b0, stall_v = 1'b0, force_v = 1'b0;
    logic [31:0] force_pc_v = '0;
    logic [31:0] exp_pc;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // One cycle: apply controls and memory responses at negedge, record the grant before posedge.
    task automatic step();
        @(negedge clk_i);
        cyc++;
        srstn_i       = rst_v;
        cu_kill_f_i   = kill_v;
        cu_stall_f_i  = stall_v;
        cu_force_f_i  = force_v;
        cu_force_pc_i = force_pc_v;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = pend[0].addr ^ KEY;
            pend.delete(0);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
        if (gnt_off > 0) begin
            instr_gnt_i = 1'b0;
            gnt_off--;
        end else begin
            instr_gnt_i = (grants_left > 0) && (!gnt_rand || ($urandom_range(0, 1) == 1));
        end
        #1;
        if (prev_wait && srstn_i && !cu_force_f_i && instr_req_o)
            check("addr_stable", instr_addr_o, prev_addr);
        if (instr_req_o && instr_gnt_i) begin
            pend.push_back('{instr_addr_o, cyc + int'($urandom_range(lat_min, lat_max))});
            grants_left--;
            check("inflight_max", 32'(pend.size() <= MAX_OUTST), 32'd1);
        end
        prev_wait = srstn_i && instr_req_o && !instr_gnt_i;
        prev_addr = instr_addr_o;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (exp_q.size() != 0 || pend.size() != 0); i++) step();
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every freshly loaded output is popped against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (f_valid_o && !cu_stall_f_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h expected none", f_current_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", f_current_pc_o, e);
                    check("out_instr", f_instr_o, e ^ KEY);
                    check("out_next_pc", f_next_pc_o, e + 32'd4);
                end
            end
        end
    end

    initial begin
        exp_pc = RESET_PC;
        repeat (3) step();
        check("reset_valid", 32'(f_valid_o), 32'd0);
        check("reset_req", 32'(instr_req_o), 32'd0);
        check("stall_req_tied", 32'(f_stall_req_o), 32'd0);

        // Zero-wait memory from reset release: valid three cycles later, back-to-back PCs.
        grants_left = 3;
        push_exp(3);
        rst_v = 1'b1;
        step();
        check("req_release_cycle", 32'(instr_req_o), 32'd0);
        step();
        check("first_req", 32'(instr_req_o), 32'd1);
        check("first_addr", instr_addr_o, RESET_PC);
        check("valid_lat1", 32'(f_valid_o), 32'd0);
        step();
        check("valid_lat2", 32'(f_valid_o), 32'd0);
        step();
        check("valid_lat3", 32'(f_valid_o), 32'd1);
        drain(40);

        // Long stall fills the FIFO and throttles requests.
        grants_left = 8;
        push_exp(8);
        stall_v = 1'b1;
        repeat (10) step();
        check("stall_fifo_full", 32'(dut.u_fifo.cnt_q), 32'd4);
        check("stall_req_low", 32'(instr_req_o), 32'd0);
        stall_v = 1'b0;
        drain(60);

        // Kill in mid-stream invalidates one cycle without skipping a PC.
        grants_left = 6;
        push_exp(6);
        repeat (4) step();
        kill_v = 1'b1;
        step();
        kill_v = 1'b0;
        step();
        check("kill_valid", 32'(f_valid_o), 32'd0);
        drain(60);

        // Redirect with two requests in flight: both stale responses dropped.
        lat_min = 4;
        lat_max = 4;
        grants_left = 2;
        for (int i = 0; i < 20 && pend.size() < 2; i++) step();
        check("force_setup_inflight", 32'(pend.size()), 32'd2);
        force_v = 1'b1;
        force_pc_v = 32'h0000_0200;
        lat_min = 1;
        lat_max = 1;
        grants_left = 3;
        exp_pc = 32'h0000_0200;
        push_exp(3);
        step();
        force_v = 1'b0;
        step();
        check("force_discard", 32'(dut.discard_q), 32'd2);
        check("force_valid", 32'(f_valid_o), 32'd0);
        drain(80);
        check("discard_end", 32'(dut.discard_q), 32'd0);

        // Grant withheld for five cycles, then random grant and response delays.
        gnt_off = 5;
        gnt_rand = 1'b1;
        lat_min = 1;
        lat_max = 3;
        grants_left = 12;
        push_exp(12);
        drain(300);
        gnt_rand = 1'b0;
        lat_min = 1;
        lat_max = 1;

        // Reset with the FIFO full, then refetch from the reset PC.
        stall_v = 1'b1;
        grants_left = 6;
        repeat (10) step();
        check("prereset_fifo_full", 32'(dut.u_fifo.cnt_q), 32'd4);
        rst_v = 1'b0;
        stall_v = 1'b0;
        grants_left = 0;
        pend.delete();
        step();
        check("reset_req_low", 32'(instr_req_o), 32'd0);
        rst_v = 1'b1;
        grants_left = 3;
        exp_pc = RESET_PC;
        push_exp(3);
        step();
        check("midreset_valid", 32'(f_valid_o), 32'd0);
        check("midreset_cnt", 32'(dut.u_fifo.cnt_q), 32'd0);
        step();
        check("refetch_addr", instr_addr_o, RESET_PC);
        drain(40);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
